// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_pkg
//  Description : Shared register-file constants and writeback requester ids
//                used by the register-file write arbiter and its round-robin
//                grant sub-module.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

   localparam int                    REG_ADDR_W = 5;
   localparam int                    REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;

   // Requester ids; also the encoding of grant_id / last_grant.
   localparam logic REQ_ALU  = 1'b0;
   localparam logic REQ_LOAD = 1'b1;

endpackage : regfile_write_arbiter_pkg
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_rr_arbiter2
//  Description : Two-way round-robin arbiter (rr_arbiter2) with its own
//                last-grant flop. Generic valid/ready grant so it can be
//                reused for other shared ports.
//  Ports       : clk, rst_n    - clock, asynchronous active-low reset
//                req_valid[1:0]- per-requester request
//                req_ready[1:0]- one-hot (or zero) grant, combinational
//                grant_id      - index of the granted requester this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter_rr_arbiter2
   import regfile_write_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_valid,
   output logic [1:0] req_ready,
   output logic       grant_id
);

   logic       r_last_grant;
   logic [1:0] w_ready;

   // Grant decision. A ready is never asserted without its own valid, so
   // valid && ready reduces to ready, and each ready depends only on the
   // valids and the history flop. Readies are held low while in reset.
   always_comb begin
      w_ready = 2'b00;
      if (rst_n) begin
         case (req_valid)
            2'b01:   w_ready = 2'b01;
            2'b10:   w_ready = 2'b10;
            2'b11:   w_ready = (r_last_grant == REQ_ALU) ? 2'b10 : 2'b01;
            default: w_ready = 2'b00;
         endcase
      end
   end

   // Reset value REQ_LOAD so that the ALU requester wins the first contest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= REQ_LOAD;
      end else if (|w_ready) begin
         r_last_grant <= w_ready[1];
      end
   end

   assign req_ready = w_ready;
   assign grant_id  = w_ready[1];

endmodule : regfile_write_arbiter_rr_arbiter2
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the single register_file write port between the ALU
//                writeback (requester 0) and the load / multi-cycle writeback
//                (requester 1). Round-robin grant, one registered output
//                stage (latency 1), writes to register 0 are dropped here.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                reqN_valid/ready/addr/data - per-requester handshake
//                rf_write, rf_addr, rf_data - registered register_file port
//                grant_id                   - owner of the current rf_write
//  Optional    : REGFILE_WRITE_ARB_BYPASS_EN adds rd_addr_a/b, rf_data_a/b
//                inputs and fwd_data_a/b outputs that forward the write in
//                flight over the raw register_file read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_data,
   output logic              grant_id
`ifdef REGFILE_WRITE_ARB_BYPASS_EN
   ,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   input  logic [DATA_W-1:0] rf_data_a,
   input  logic [DATA_W-1:0] rf_data_b,
   output logic [DATA_W-1:0] fwd_data_a,
   output logic [DATA_W-1:0] fwd_data_b
`endif
);

   logic [1:0]        w_ready;
   logic              w_grant_id;
   logic              w_accept;
   logic              w_commit;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_data;

   logic              r_rf_write;
   logic [ADDR_W-1:0] r_rf_addr;
   logic [DATA_W-1:0] r_rf_data;
   logic              r_grant_id;

   regfile_write_arbiter_rr_arbiter2 u_rr_arbiter2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid ({req1_valid, req0_valid}),
      .req_ready (w_ready),
      .grant_id  (w_grant_id)
   );

   assign req0_ready = w_ready[0];
   assign req1_ready = w_ready[1];

   assign w_accept   = |w_ready;
   assign w_sel_addr = (w_grant_id == REQ_LOAD) ? req1_addr : req0_addr;
   assign w_sel_data = (w_grant_id == REQ_LOAD) ? req1_data : req0_data;

   // A transfer to register 0 is still accepted (the requester sees ready and
   // the arbiter history advances) but never reaches the register file.
   assign w_commit   = w_accept && (w_sel_addr != '0);

   // Output stage drains every cycle, so no back-pressure reaches the
   // arbiter. Address/data/id only load on a real write and otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_write <= 1'b0;
         r_rf_addr  <= '0;
         r_rf_data  <= '0;
         r_grant_id <= REQ_ALU;
      end else begin
         r_rf_write <= w_commit;
         if (w_commit) begin
            r_rf_addr  <= w_sel_addr;
            r_rf_data  <= w_sel_data;
            r_grant_id <= w_grant_id;
         end
      end
   end

   assign rf_write = r_rf_write;
   assign rf_addr  = r_rf_addr;
   assign rf_data  = r_rf_data;
   assign grant_id = r_grant_id;

`ifdef REGFILE_WRITE_ARB_BYPASS_EN
   // The register file commits at the end of the rf_write cycle, so a read of
   // the same register during that cycle would see stale data. Forward the
   // in-flight value instead; register 0 is never forwarded.
   assign fwd_data_a = (r_rf_write && (rd_addr_a == r_rf_addr) && (rd_addr_a != '0))
                       ? r_rf_data : rf_data_a;
   assign fwd_data_b = (r_rf_write && (rd_addr_b == r_rf_addr) && (rd_addr_b != '0))
                       ? r_rf_data : rf_data_b;
`endif

endmodule : regfile_write_arbiter
`default_nettype wire
